fetch_stage: RTL and testbench

Instruction-fetch front end sitting directly upstream of the ID pipeline register bank.
- Owns the architectural fetch PC.
- Issues in-order requests to instruction memory over a req/gnt + rvalid interface.
- Buffers returned words with their PC in a small queue.
- Hands {instr, PC, PC+4} to decode over a valid/ready handshake.
- Redirects from EX (branch, JAL, JALR, CSR trap) flush the queue and squash in-flight responses.

---
 rtl/fetch_stage_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 55 +++++
 rtl/fetch_stage.sv | 113 +++++++++++
 tb/tb_fetch_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_stage_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h2000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO: one-cycle write-to-read, flush beats push/pop.
// Pop on empty and push on full (without a same-cycle pop) are ignored.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop    = pop && (count != '0);
  assign do_push   = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: nothing reads it until count says it was written.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch front end: owns the PC, issues in-order imem requests, queues words for decode.
// gnt at t -> rvalid at t+1 -> inst_valid at t+2; requests are throttled so responses never need backpressure.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR    = RESET_VECTOR_DEFAULT,
  parameter int              FIFO_DEPTH      = 2,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_ID,
  output logic [XLEN-1:0] PC_ID,
  output logic [XLEN-1:0] PCplus4_ID,
  output logic            fetch_busy
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int QW = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0] fetch_pc;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   drop_cnt;
  logic [OW-1:0]   pend_count;
  logic [QW-1:0]   q_count;
  logic [XLEN-1:0] pend_pc;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;
  logic            accept;
  logic            rsp;
  logic            rsp_keep;

  assign imem_addr = fetch_pc;
  assign accept    = imem_req && imem_gnt;
  assign rsp       = imem_rvalid && (outstanding != '0);
  assign rsp_keep  = rsp && (drop_cnt == '0);

  // Every live (non-dropped) in-flight request must already own a queue slot.
  assign imem_req = !reset && !redirect
                 && (int'(outstanding) < MAX_OUTSTANDING)
                 && (int'(outstanding) + int'(q_count) < FIFO_DEPTH + int'(drop_cnt));

  assign push_entry = '{instr: imem_rdata, pc: pend_pc};

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_out_q (
    .clk       (clk),
    .reset     (reset),
    .push      (rsp_keep),
    .push_data (push_entry),
    .pop       (inst_valid && inst_ready),
    .flush     (redirect),
    .head_data (head_entry),
    .count     (q_count)
  );

  // Pending PCs survive a redirect so dropped responses still pop in order.
  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pend_q (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (fetch_pc),
    .pop       (rsp),
    .flush     (1'b0),
    .head_data (pend_pc),
    .count     (pend_count)
  );

  assign inst_valid = (q_count != '0);
  assign inst_ID    = inst_valid ? head_entry.instr : '0;
  assign PC_ID      = inst_valid ? head_entry.pc : '0;
  assign PCplus4_ID = inst_valid ? head_entry.pc + 32'd4 : '0;
  assign fetch_busy = (outstanding != '0) || (drop_cnt != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_VECTOR;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + OW'(accept) - OW'(rsp);
      if (redirect) begin
        fetch_pc <= word_align(redirect_pc);
        // Everything still in flight after this cycle is stale, earlier drops included.
        drop_cnt <= outstanding - OW'(rsp);
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (rsp && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  a_rvalid_orphan: assert property (@(posedge clk) disable iff (reset)
    imem_rvalid |-> (outstanding != '0));

  a_pend_tracks_outstanding: assert property (@(posedge clk) disable iff (reset)
    pend_count == outstanding);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, backpressure, redirects, async reset, PC wrap.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_ID;
  logic [31:0] PC_ID;
  logic [31:0] PCplus4_ID;
  logic        fetch_busy;

  int n_checks = 0;
  int n_fail = 0;
  bit mem_auto = 1'b0;

  logic [31:0] gaddr [16];
  logic [31:0] dpc [16];
  logic [31:0] dp4 [16];
  logic [31:0] din [16];
  int ng, nd, first_g, first_v;

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_ID     (inst_ID),
    .PC_ID       (PC_ID),
    .PCplus4_ID  (PCplus4_ID),
    .fetch_busy  (fetch_busy)
  );

  always #5 clk = ~clk;

  // Auto memory: answers each grant exactly one cycle later with ~addr.
  initial begin
    bit g;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      #2;
      g = mem_auto && imem_req && imem_gnt;
      a = imem_addr;
      @(posedge clk);
      #1;
      if (mem_auto) begin
        imem_rvalid = g;
        imem_rdata  = g ? ~a : 32'h0;
      end
    end
  end

  task automatic do_reset;
    @(negedge clk);
    mem_auto = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0;
    redirect_pc = 32'h0; inst_ready = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic clear_log;
    ng = 0; nd = 0; first_g = -1; first_v = -1;
  endtask

  task automatic sample_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      #1;
      if (imem_req && imem_gnt) begin
        if (ng < 16) gaddr[ng] = imem_addr;
        if (first_g < 0) first_g = k;
        ng++;
      end
      if (inst_valid) begin
        if (first_v < 0) first_v = k;
        if (inst_ready) begin
          if (nd < 16) begin dpc[nd] = PC_ID; dp4[nd] = PCplus4_ID; din[nd] = inst_ID; end
          nd++;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic drain;
    imem_gnt = 1'b0; inst_ready = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %0b want 0", imem_req); end
    n_checks++; if (imem_addr !== 32'h2000) begin n_fail++; $display("FAIL rst_addr got %h want 00002000", imem_addr); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %0b want 0", inst_valid); end
    n_checks++; if (inst_ID !== 32'h0) begin n_fail++; $display("FAIL rst_inst got %h want 0", inst_ID); end
    n_checks++; if (PC_ID !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %h want 0", PC_ID); end
    n_checks++; if (PCplus4_ID !== 32'h0) begin n_fail++; $display("FAIL rst_pc4 got %h want 0", PCplus4_ID); end
    n_checks++; if (fetch_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %0b want 0", fetch_busy); end
  endtask

  task automatic test_stream;
    do_reset;
    imem_gnt = 1'b1; inst_ready = 1'b1; mem_auto = 1'b1;
    clear_log;
    sample_cycles(12);
    n_checks++; if (gaddr[0] !== 32'h2000) begin n_fail++; $display("FAIL stream_g0 got %h want 00002000", gaddr[0]); end
    n_checks++; if (gaddr[1] !== 32'h2004) begin n_fail++; $display("FAIL stream_g1 got %h want 00002004", gaddr[1]); end
    n_checks++; if (gaddr[2] !== 32'h2008) begin n_fail++; $display("FAIL stream_g2 got %h want 00002008", gaddr[2]); end
    n_checks++; if (first_v - first_g !== 2) begin n_fail++; $display("FAIL stream_latency got %0d want 2", first_v - first_g); end
    n_checks++; if (dpc[0] !== 32'h2000) begin n_fail++; $display("FAIL stream_pc0 got %h want 00002000", dpc[0]); end
    n_checks++; if (dp4[0] !== 32'h2004) begin n_fail++; $display("FAIL stream_pc4_0 got %h want 00002004", dp4[0]); end
    n_checks++; if (din[0] !== 32'hFFFFDFFF) begin n_fail++; $display("FAIL stream_inst0 got %h want ffffdfff", din[0]); end
    n_checks++; if (dpc[1] !== 32'h2004) begin n_fail++; $display("FAIL stream_pc1 got %h want 00002004", dpc[1]); end
    n_checks++; if (dp4[1] !== 32'h2008) begin n_fail++; $display("FAIL stream_pc4_1 got %h want 00002008", dp4[1]); end
    drain;
  endtask

  task automatic test_backpressure;
    do_reset;
    imem_gnt = 1'b1; inst_ready = 1'b0; mem_auto = 1'b1;
    clear_log;
    sample_cycles(8);
    #1;
    n_checks++; if (ng !== 2) begin n_fail++; $display("FAIL bp_grants got %0d want 2", ng); end
    n_checks++; if (gaddr[0] !== 32'h2000) begin n_fail++; $display("FAIL bp_g0 got %h want 00002000", gaddr[0]); end
    n_checks++; if (gaddr[1] !== 32'h2004) begin n_fail++; $display("FAIL bp_g1 got %h want 00002004", gaddr[1]); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_held got %0b want 0", imem_req); end
    n_checks++; if (PC_ID !== 32'h2000 || inst_valid !== 1'b1) begin n_fail++; $display("FAIL bp_head got %h/%0b want 00002000/1", PC_ID, inst_valid); end
    inst_ready = 1'b1;
    clear_log;
    sample_cycles(10);
    n_checks++; if (dpc[0] !== 32'h2000) begin n_fail++; $display("FAIL bp_d0 got %h want 00002000", dpc[0]); end
    n_checks++; if (dpc[1] !== 32'h2004) begin n_fail++; $display("FAIL bp_d1 got %h want 00002004", dpc[1]); end
    n_checks++; if (gaddr[0] !== 32'h2008) begin n_fail++; $display("FAIL bp_resume got %h want 00002008", gaddr[0]); end
    n_checks++; if (dpc[2] !== 32'h2008 || din[2] !== 32'hFFFFDFF7) begin n_fail++; $display("FAIL bp_d2 got %h/%h want 00002008/ffffdff7", dpc[2], din[2]); end
    drain;
  endtask

  task automatic test_redirect_drop;
    do_reset;
    imem_gnt = 1'b1; inst_ready = 1'b1;
    #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h2000) begin n_fail++; $display("FAIL rd_req0 got %0b/%h want 1/00002000", imem_req, imem_addr); end
    @(negedge clk); #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h2004) begin n_fail++; $display("FAIL rd_req1 got %0b/%h want 1/00002004", imem_req, imem_addr); end
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h3003;
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rd_req_in_redirect got %0b want 0", imem_req); end
    @(negedge clk);
    redirect = 1'b0; imem_gnt = 1'b0;
    #1;
    n_checks++; if (imem_addr !== 32'h3000) begin n_fail++; $display("FAIL rd_target got %h want 00003000", imem_addr); end
    n_checks++; if (fetch_busy !== 1'b1) begin n_fail++; $display("FAIL rd_busy got %0b want 1", fetch_busy); end
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD02000;
    @(negedge clk);
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rd_drop0 got %0b want 0", inst_valid); end
    imem_rdata = 32'hBAD02004;
    @(negedge clk);
    imem_rvalid = 1'b0;
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rd_drop1 got %0b want 0", inst_valid); end
    n_checks++; if (fetch_busy !== 1'b0) begin n_fail++; $display("FAIL rd_idle got %0b want 0", fetch_busy); end
    imem_gnt = 1'b1;
    #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin n_fail++; $display("FAIL rd_new_req got %0b/%h want 1/00003000", imem_req, imem_addr); end
    @(negedge clk);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hCAFE0001;
    @(negedge clk);
    imem_rvalid = 1'b0;
    n_checks++; if (inst_valid !== 1'b1 || PC_ID !== 32'h3000) begin n_fail++; $display("FAIL rd_first got %0b/%h want 1/00003000", inst_valid, PC_ID); end
    n_checks++; if (inst_ID !== 32'hCAFE0001 || PCplus4_ID !== 32'h3004) begin n_fail++; $display("FAIL rd_first_data got %h/%h want cafe0001/00003004", inst_ID, PCplus4_ID); end
    @(negedge clk);
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rd_popped got %0b want 0", inst_valid); end
  endtask

  task automatic test_redirect_flush;
    do_reset;
    imem_gnt = 1'b1; inst_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hD0D02000;
    @(negedge clk);
    n_checks++; if (inst_valid !== 1'b1 || PC_ID !== 32'h2000) begin n_fail++; $display("FAIL fl_setup got %0b/%h want 1/00002000", inst_valid, PC_ID); end
    inst_ready = 1'b1; imem_rdata = 32'hD0D02004; redirect = 1'b1; redirect_pc = 32'h4000;
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL fl_req got %0b want 0", imem_req); end
    @(negedge clk);
    redirect = 1'b0; imem_rvalid = 1'b0;
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL fl_empty got %0b want 0", inst_valid); end
    n_checks++; if (fetch_busy !== 1'b0) begin n_fail++; $display("FAIL fl_busy got %0b want 0", fetch_busy); end
    imem_gnt = 1'b1;
    #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4000) begin n_fail++; $display("FAIL fl_req_new got %0b/%h want 1/00004000", imem_req, imem_addr); end
    @(negedge clk);
    imem_gnt = 1'b0;
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL fl_no_stale got %0b want 0", inst_valid); end
    imem_rvalid = 1'b1; imem_rdata = 32'hCAFE4000;
    @(negedge clk);
    imem_rvalid = 1'b0;
    n_checks++; if (inst_valid !== 1'b1 || PC_ID !== 32'h4000 || inst_ID !== 32'hCAFE4000) begin n_fail++; $display("FAIL fl_first got %0b/%h/%h want 1/00004000/cafe4000", inst_valid, PC_ID, inst_ID); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    do_reset;
    imem_gnt = 1'b1; inst_ready = 1'b0;
    @(negedge clk);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0BAD0BAD;
    @(negedge clk);
    imem_rvalid = 1'b0; imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    n_checks++; if (inst_valid !== 1'b1 || fetch_busy !== 1'b1) begin n_fail++; $display("FAIL rm_setup got %0b/%0b want 1/1", inst_valid, fetch_busy); end
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid got %0b want 0", inst_valid); end
    n_checks++; if (imem_addr !== 32'h2000) begin n_fail++; $display("FAIL rm_addr got %h want 00002000", imem_addr); end
    n_checks++; if (fetch_busy !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL rm_idle got %0b/%0b want 0/0", fetch_busy, imem_req); end
    @(negedge clk);
    reset = 1'b0; imem_gnt = 1'b1;
    #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h2000) begin n_fail++; $display("FAIL rm_restart got %0b/%h want 1/00002000", imem_req, imem_addr); end
    @(negedge clk);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00000055;
    @(negedge clk);
    imem_rvalid = 1'b0;
    n_checks++; if (inst_valid !== 1'b1 || PC_ID !== 32'h2000 || inst_ID !== 32'h55) begin n_fail++; $display("FAIL rm_first got %0b/%h/%h want 1/00002000/00000055", inst_valid, PC_ID, inst_ID); end
    inst_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_wrap;
    do_reset;
    imem_gnt = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFFFFFC;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL wr_a0 got %0b/%h want 1/fffffffc", imem_req, imem_addr); end
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL wr_a1 got %0b/%h want 1/00000000", imem_req, imem_addr); end
    imem_rvalid = 1'b1; imem_rdata = 32'h11111111;
    @(negedge clk);
    n_checks++; if (inst_valid !== 1'b1 || PC_ID !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL wr_pc got %0b/%h want 1/fffffffc", inst_valid, PC_ID); end
    n_checks++; if (PCplus4_ID !== 32'h0) begin n_fail++; $display("FAIL wr_pc4 got %h want 00000000", PCplus4_ID); end
    inst_ready = 1'b1; imem_rdata = 32'h22222222;
    @(negedge clk);
    #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL wr_a2 got %0b/%h want 1/00000004", imem_req, imem_addr); end
    n_checks++; if (PC_ID !== 32'h0 || PCplus4_ID !== 32'h4 || inst_ID !== 32'h22222222) begin n_fail++; $display("FAIL wr_next got %h/%h/%h want 00000000/00000004/22222222", PC_ID, PCplus4_ID, inst_ID); end
    imem_gnt = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_redirect_drop;
    test_redirect_flush;
    test_reset_mid;
    test_wrap;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
